// File: rtl/sound_btn_conditioner_pkg.sv
// sound_btn_pkg: shared channel states and index constants for the button conditioner
package sound_btn_pkg;
    typedef enum logic [1:0] {IDLE_LO, CONFIRM_HI, HELD_HI, CONFIRM_LO} btn_state_t;
    localparam int LOW_BATT_IDX = 8;
    localparam logic [3:0] IDX_NONE = 4'hF;
endpackage

// File: rtl/sound_btn_conditioner_if.sv
// sound_btn_if: raw button inputs and conditioned outputs between the pad side and the sound core
interface sound_btn_if #(parameter int NUM_BTN = 9);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic [3:0] active_idx;
    logic any_active;
    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, active_idx, any_active
    );
    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, active_idx, any_active
    );
endinterface

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: two-flop synchroniser, debounce FSM and stability counter for one button
module btn_debounce_ch
    import sound_btn_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W = 16
`ifdef SOUND_BTN_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_PERIOD = 100000
`endif
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);
    btn_state_t state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic press_q, press_d;
    logic rel_q, rel_d;
    logic s, done;
    assign s = sync_q[1];
    assign done = cnt_q == CNT_W'(DB_CYCLES - 1);
    assign sync_d = {sync_q[0], raw};
    assign level = state_q == HELD_HI || state_q == CONFIRM_LO;
    assign press = press_q;
    assign rel = rel_q;
`ifdef SOUND_BTN_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    logic [REP_W-1:0] rep_q, rep_d;
    logic rep_hit;
    // after the first repeat the counter reloads so later hits land every REPEAT_PERIOD
    assign rep_hit = state_q == HELD_HI && s && rep_q == REP_W'(REPEAT_DELAY - 1);
    assign rep_d = state_q != HELD_HI ? '0 :
                   rep_q == REP_W'(REPEAT_DELAY - 1) ? REP_W'(REPEAT_DELAY - REPEAT_PERIOD) :
                   rep_q + 1'b1;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) rep_q <= '0;
        else rep_q <= rep_d;
    end
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        press_d = 1'b0;
        rel_d = 1'b0;
        case (state_q)
            IDLE_LO: if (s) begin
                state_d = CONFIRM_HI;
                cnt_d = '0;
            end
            CONFIRM_HI: if (!s) state_d = IDLE_LO;
                else if (done) begin
                    state_d = HELD_HI;
                    press_d = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
            HELD_HI: if (!s) begin
                state_d = CONFIRM_LO;
                cnt_d = '0;
            end
            CONFIRM_LO: if (s) state_d = HELD_HI;
                else if (done) begin
                    state_d = IDLE_LO;
                    rel_d = 1'b1;
                end else cnt_d = cnt_q + 1'b1;
        endcase
`ifdef SOUND_BTN_REPEAT_EN
        press_d = press_d | rep_hit;
`endif
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE_LO;
            sync_q <= '0;
            cnt_q <= '0;
            press_q <= 1'b0;
            rel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q <= sync_d;
            cnt_q <= cnt_d;
            press_q <= press_d;
            rel_q <= rel_d;
        end
    end
endmodule

// File: rtl/sound_btn_conditioner.sv
// sound_btn_conditioner: debounced button front end for the hk628 sound core; SOUND_BTN_REPEAT_EN adds auto-repeat press pulses
module sound_btn_conditioner
    import sound_btn_pkg::*;
#(
    parameter int NUM_BTN = LOW_BATT_IDX + 1,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W = 16
`ifdef SOUND_BTN_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 500000,
    parameter int REPEAT_PERIOD = 100000
`endif
) (
    input logic clk_sys,
    input logic reset_n,
    sound_btn_if.slave bus
);
    logic [NUM_BTN-1:0] level, press, rel;
    logic [3:0] idx_q, idx_d;
    logic any_q, any_d;
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W(CNT_W)
`ifdef SOUND_BTN_REPEAT_EN
            ,
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .raw(bus.btn_raw[g]),
            .level(level[g]),
            .press(press[g]),
            .rel(rel[g])
        );
    end
    // descending scan so the lowest set index wins; low-battery is last in line
    always_comb begin
        idx_d = IDX_NONE;
        for (int i = NUM_BTN - 1; i >= 0; i--) if (level[i]) idx_d = 4'(i);
        any_d = |level;
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            idx_q <= IDX_NONE;
            any_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            any_q <= any_d;
        end
    end
    assign bus.btn_level = level;
    assign bus.btn_press = press;
    assign bus.btn_release = rel;
    assign bus.active_idx = idx_q;
    assign bus.any_active = any_q;
endmodule

// File: doc/sound_btn_conditioner.md
Name: sound_btn_conditioner

Overview:
Input-conditioning stage directly upstream of the hk628 sound core. Takes raw joystick_0 bits [8:0] (8 tone buttons plus the low-battery button), then synchronises and debounces each one. Produces clean levels, one-cycle press/release pulses and a priority-encoded active-button index. Its outputs drive the sound core's btn and low_batt_btn inputs, so the core never sees contact bounce or metastable edges.

Parameters:
NUM_BTN, 9, number of button channels (bit 8 = low-battery).
DB_CYCLES, 50000, consecutive stable clk_sys samples needed to accept a level change; legal range 2..65535.
CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DB_CYCLES.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
btn_raw  in  NUM_BTN  raw button inputs, asynchronous to clk_sys, active-high
btn_level  out  NUM_BTN  debounced level per button
btn_press  out  NUM_BTN  one-cycle pulse on accepted 0->1
btn_release  out  NUM_BTN  one-cycle pulse on accepted 1->0
active_idx  out  4  lowest-numbered button with btn_level=1; 4'hF when none
any_active  out  1  OR of btn_level

Behaviour:
- Single clock (clk_sys), asynchronous active-low reset_n. All state is cleared asynchronously on reset_n=0.
- Reset values: btn_level=0, btn_press=0, btn_release=0, active_idx=4'hF, any_active=0, every channel in IDLE_LO, counters=0, synchroniser flops=0.
- Synchroniser: 2-flop per bit. The synced sample s is valid 2 edges after btn_raw changes.
- Per-channel FSM with 4 states: IDLE_LO, CONFIRM_HI, HELD_HI, CONFIRM_LO.
  - IDLE_LO: s=1 -> CONFIRM_HI, cnt<=0.
  - CONFIRM_HI: s=0 -> IDLE_LO (bounce rejected, no pulse). s=1 and cnt==DB_CYCLES-1 -> HELD_HI, btn_level<=1, btn_press<=1 for one cycle. Otherwise cnt<=cnt+1.
  - HELD_HI: s=0 -> CONFIRM_LO, cnt<=0.
  - CONFIRM_LO: mirrors CONFIRM_HI. On acceptance -> IDLE_LO, btn_level<=0, btn_release<=1.
- Latency: a btn_raw step held stable asserts btn_level on the (DB_CYCLES+3)th rising edge after the step is sampled. btn_press rises on that same edge.
- Counter saturates by construction (it never exceeds DB_CYCLES-1); no wrap is possible.
- Any glitch shorter than DB_CYCLES samples produces no level change and no pulse. A glitch during CONFIRM restarts the count from 0 on the next qualifying edge.
- Channels are fully independent. Simultaneous acceptances on several channels in the same cycle each produce their own pulse.
- active_idx/any_active are registered from btn_level, so they lag btn_level by 1 cycle. Priority goes to the lowest index; bit 8 (low-battery) has the lowest priority.
- Asserting reset_n mid-confirm or mid-hold discards everything. No release pulse is emitted for a held button.

Optional Feature:
Macro SOUND_BTN_REPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 500000) and REPEAT_PERIOD (default 100000) plus a per-channel repeat counter.
  - In HELD_HI, btn_press re-pulses once REPEAT_DELAY cycles after acceptance, then every REPEAT_PERIOD cycles until leaving HELD_HI.
  - The repeat counter clears on entry to HELD_HI.
  - btn_level is unaffected.
- Undefined: exactly one btn_press per accepted press; no repeat logic or parameters are synthesised.

Decomposition:
- Package sound_btn_pkg holds:
  - btn_state_t enum (IDLE_LO, CONFIRM_HI, HELD_HI, CONFIRM_LO);
  - localparam LOW_BATT_IDX=8;
  - localparam IDX_NONE=4'hF.
- Sub-module btn_debounce_ch: synchroniser, FSM and counter for one channel.
- Top level: generates NUM_BTN instances plus the registered priority encoder.

Test Plan (bench uses DB_CYCLES=8):
- Reset: reset_n=0 with btn_raw=9'h1FF -> all outputs at reset values. After release with btn_raw still 9'h1FF, btn_level=9'h1FF on edge 11; btn_press=9'h1FF for exactly 1 cycle; active_idx=0 one cycle later.
- Bounce: btn_raw[3] toggles 1/0 every 3 cycles for 40 cycles, then held 0 -> btn_level[3] stays 0 and no press/release pulses.
- Clean press/release: btn_raw[2] 0->1 held 20 cycles -> btn_press[2] pulse on edge 11. Then 1->0 -> btn_release[2] pulse 11 edges later; active_idx back to 4'hF.
- Priority: buttons 5 and 8 held, then button 1 pressed -> active_idx 5 -> 1. Release 1 -> 5. Release 5 -> 8. Release 8 -> 4'hF.
- Reset mid-hold: btn_raw[0] accepted, then reset_n pulsed low for 1 cycle -> btn_level[0]=0 immediately and no release pulse. The level is re-accepted 11 edges after reset deassert.
- SOUND_BTN_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5: button 4 held 40 cycles past acceptance -> press pulses at acceptance, +20, +25, +30, +35, +40.
